// File: rtl/hatch_obi_arbiter.sv
// Shares one in-order OBI memory port between the instruction and data masters.
// Define HATCH_ARB_RR_EN for round-robin tie breaking; otherwise data always beats instr.
module hatch_obi_arbiter #(
  parameter int MaxOutstanding = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  instr_req_i,
  output logic                                  instr_gnt_o,
  input  logic [AddrWidth-1:0]                  instr_addr_i,
  output logic                                  instr_rvalid_o,
  output logic [DataWidth-1:0]                  instr_rdata_o,
  output logic                                  instr_err_o,
  input  logic                                  data_req_i,
  output logic                                  data_gnt_o,
  input  logic [AddrWidth-1:0]                  data_addr_i,
  input  logic                                  data_we_i,
  input  logic [DataWidth/8-1:0]                data_be_i,
  input  logic [DataWidth-1:0]                  data_wdata_i,
  output logic                                  data_rvalid_o,
  output logic [DataWidth-1:0]                  data_rdata_o,
  output logic                                  data_err_o,
  output logic                                  mem_req_o,
  input  logic                                  mem_gnt_i,
  output logic [AddrWidth-1:0]                  mem_addr_o,
  output logic                                  mem_we_o,
  output logic [DataWidth/8-1:0]                mem_be_o,
  output logic [DataWidth-1:0]                  mem_wdata_o,
  input  logic                                  mem_rvalid_i,
  input  logic [DataWidth-1:0]                  mem_rdata_i,
  input  logic                                  mem_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  unexp_rvalid_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              owner;
  logic              req;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              tie_data;
  logic              head;
  logic              fifo_q [MaxOutstanding];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              unexp_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

`ifdef HATCH_ARB_RR_EN
  // rr_q=1 means the data master wins the next simultaneous request.
  logic rr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else if (push) begin
      rr_q <= ~owner;
    end
  end

  assign tie_data = rr_q;
`else
  assign tie_data = 1'b1;
`endif

  assign full  = (count_q == CntW'(MaxOutstanding));
  assign empty = (count_q == '0);

  // Owner of the memory port: fresh pick in IDLE, the locked owner until it is granted.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req     = 1'b0;
    owner   = owner_q;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (!full && (instr_req_i || data_req_i)) begin
            req   = 1'b1;
            owner = data_req_i && (!instr_req_i || tie_data);
            if (!mem_gnt_i) begin
              state_d = LOCKED;
              owner_d = owner;
            end
          end
        end
        LOCKED: begin
          req   = 1'b1;
          owner = owner_q;
          if (mem_gnt_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign push = req & mem_gnt_i;
  assign pop  = mem_rvalid_i & ~empty & ~rst_i;
  assign head = fifo_q[rd_ptr_q];

  assign mem_req_o   = req;
  assign instr_gnt_o = push & ~owner;
  assign data_gnt_o  = push & owner;

  assign mem_addr_o  = owner ? data_addr_i  : instr_addr_i;
  assign mem_we_o    = owner ? data_we_i    : 1'b0;
  assign mem_be_o    = owner ? data_be_i    : '1;
  assign mem_wdata_o = owner ? data_wdata_i : '0;

  assign instr_rvalid_o = pop & ~head;
  assign data_rvalid_o  = pop & head;
  assign instr_err_o    = pop & ~head & mem_err_i;
  assign data_err_o     = pop & head & mem_err_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign outstanding_o  = count_q;
  assign unexp_rvalid_o = unexp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      unexp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (mem_rvalid_i && empty) begin
        unexp_q <= 1'b1;
      end
    end
  end

  // ID storage needs no reset: occupancy and pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= owner;
    end
  end

endmodule
